// File: rtl/dac_sample_feeder_pkg.sv
// rtl/dac_sample_feeder_pkg.sv - shared width, FSM states and sample conversion for dac_sample_feeder
package dac_sample_feeder_pkg;

    localparam int DW = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    function automatic logic [DW-1:0] midscale(input bit offset_bin);
        return offset_bin ? {1'b1, {(DW-1){1'b0}}} : '0;
    endfunction

    // Two's complement to offset binary is just an MSB flip.
    function automatic logic [DW-1:0] to_dac(input logic [DW-1:0] sample, input bit offset_bin);
        return offset_bin ? {~sample[DW-1], sample[DW-2:0]} : sample;
    endfunction

endpackage

// File: rtl/dac_sample_feeder_if.sv
// rtl/dac_sample_feeder_if.sv - {ch2,ch1} sample-pair input stream
interface dac_sample_feeder_if;
    import dac_sample_feeder_pkg::*;

    logic          s_valid;
    logic          s_ready;
    logic [2*DW-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/dac_sample_feeder_fifo.sv
// rtl/dac_sample_feeder_fifo.sv - sample-pair FIFO with flush and exact occupancy
module dac_sample_feeder_fifo #(
    parameter  int WIDTH = 28,
    parameter  int DEPTH = 512,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_full  = (o_level == (AW+1)'(DEPTH));
    assign o_empty = (o_level == '0);
    assign w_push  = i_wr && !o_full && !i_flush;
    assign w_pop   = i_rd && !o_empty && !i_flush;
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/dac_sample_feeder.sv
// rtl/dac_sample_feeder.sv - rate-paced dual-channel DAC sample feeder with prefill and underflow status
module dac_sample_feeder
    import dac_sample_feeder_pkg::*;
#(
    parameter  int DEPTH       = 512,
    parameter  int PRIME_LVL   = 16,
    parameter  int OFFSET_BIN  = 1,
    parameter  int UF_MIDSCALE = 0,
    localparam int LW          = $clog2(DEPTH) + 1
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   enable,
    input  logic                   flush,
    input  logic [15:0]            rate_div,
    input  logic [1:0]             ch_en,
    dac_sample_feeder_if.slave     s_if,
    output logic [DW-1:0]          data1,
    output logic                   wrt1_en,
    output logic [DW-1:0]          data2,
    output logic                   wrt2_en,
    output logic [LW-1:0]          level,
    output logic                   underflow,
    output logic [15:0]            underflow_cnt,
    input  logic                   clr_status
);

    localparam bit              OB  = (OFFSET_BIN != 0);
    localparam logic [DW-1:0]   MID = midscale(OB);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_run;
    logic            w_run_nxt;
    logic            w_tick;
    logic            w_pop;
    logic            w_uf;
    logic            w_empty;
    logic            w_full;
    logic [2*DW-1:0] w_head;
    logic [15:0]     r_div;
    logic [15:0]     r_div_max;

    dac_sample_feeder_fifo #(.WIDTH(2*DW), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (sys_clk),
        .i_rst   (sys_rst),
        .i_flush (flush),
        .i_wr    (s_if.s_valid),
        .i_wdata (s_if.s_data),
        .i_rd    (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    assign s_if.s_ready = !w_full;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (enable) w_state_nxt = PRIME;
            PRIME:   if (level >= LW'(PRIME_LVL)) w_state_nxt = RUN;
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
        if (flush || !enable) w_state_nxt = IDLE;
    end

    always_comb begin
        w_run     = (r_state == RUN);
        w_run_nxt = (w_state_nxt == RUN);
    end

    // The period limit is latched only at wrap, so rate_div edits never cut a period short.
    assign w_tick = w_run && (r_div == r_div_max);
    assign w_pop  = w_tick && !w_empty && !flush;
    assign w_uf   = w_tick && w_empty;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || !w_run || w_tick) begin
            r_div     <= '0;
            r_div_max <= rate_div;
        end else begin
            r_div <= r_div + 16'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst || !w_run_nxt) begin
            data1 <= MID;
            data2 <= MID;
        end else if (w_pop) begin
            data1 <= to_dac(w_head[DW-1:0], OB);
            data2 <= to_dac(w_head[2*DW-1:DW], OB);
        end else if (w_uf && (UF_MIDSCALE != 0)) begin
            data1 <= MID;
            data2 <= MID;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wrt1_en <= 1'b0;
            wrt2_en <= 1'b0;
        end else begin
            wrt1_en <= ch_en[0] && w_run_nxt;
            wrt2_en <= ch_en[1] && w_run_nxt;
        end
    end

    // A clear landing on an underflow tick restarts the count at this tick.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            underflow     <= 1'b0;
            underflow_cnt <= '0;
        end else if (w_uf) begin
            underflow <= 1'b1;
            if (clr_status)                    underflow_cnt <= 16'd1;
            else if (underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
        end else if (clr_status) begin
            underflow     <= 1'b0;
            underflow_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// tb/tb_dac_sample_feeder.sv - self-checking bench for dac_sample_feeder
module tb_dac_sample_feeder;
    import dac_sample_feeder_pkg::*;

    localparam int DEPTH = 512;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic          clr_status = 1'b0;
    logic [15:0]   rate_div = 16'd3;
    logic [1:0]    ch_en = 2'b11;
    logic [DW-1:0] data1, data2;
    logic          wrt1_en, wrt2_en;
    logic [9:0]    level;
    logic          underflow;
    logic [15:0]   underflow_cnt;

    dac_sample_feeder_if u_if ();

    dac_sample_feeder #(.DEPTH(DEPTH), .PRIME_LVL(16), .OFFSET_BIN(1), .UF_MIDSCALE(0)) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .enable        (enable),
        .flush         (flush),
        .rate_div      (rate_div),
        .ch_en         (ch_en),
        .s_if          (u_if),
        .data1         (data1),
        .wrt1_en       (wrt1_en),
        .data2         (data2),
        .wrt2_en       (wrt2_en),
        .level         (level),
        .underflow     (underflow),
        .underflow_cnt (underflow_cnt),
        .clr_status    (clr_status)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [DW-1:0] ch2;
        logic [DW-1:0] ch1;
        logic [DW-1:0] exp2;
        logic [DW-1:0] exp1;
    } vec_t;

    vec_t            vecs [16];
    logic [2*DW-1:0] sb [$];
    int              n_checks = 0;
    int              n_fail = 0;
    int              cyc = 0;
    int              chg_count = 0;
    int              last_chg = 0;
    int              exp_period = 0;
    bit              mon_en = 1'b0;
    bit              have_chg = 1'b0;
    logic [2*DW-1:0] prev_out = '0;
    logic [2*DW-1:0] last_exp = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: every change of the pair consumes one scoreboard entry.
    always @(posedge sys_clk) begin
        cyc++;
        #1;
        if (mon_en && ({data2, data1} !== prev_out)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %h, scoreboard empty", {data2, data1});
            end else begin
                last_exp = sb.pop_front();
                check("sample_out", {4'h0, data2, data1}, {4'h0, last_exp});
            end
            if (have_chg && exp_period != 0) check("tick_period", cyc - last_chg, exp_period);
            have_chg  = 1'b1;
            last_chg  = cyc;
            chg_count++;
        end
        prev_out = {data2, data1};
    end

    task automatic push(input logic [DW-1:0] c2, input logic [DW-1:0] c1,
                        input logic [2*DW-1:0] exp, input bit track);
        int w = 0;
        u_if.s_valid = 1'b1;
        u_if.s_data  = {c2, c1};
        while (!u_if.s_ready && w < 2000) begin
            @(negedge sys_clk);
            w++;
        end
        if (!u_if.s_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: s_ready stuck at 0");
        end else if (track) begin
            sb.push_back(exp);
        end
        @(negedge sys_clk);
        u_if.s_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge sys_clk);
    endtask

    task automatic wait_chg(input int target, input string name);
        int w = 0;
        while (chg_count < target && w < 500) begin
            @(negedge sys_clk);
            w++;
        end
        check(name, 32'(chg_count >= target), 32'd1);
    endtask

    task automatic wait_drain(input string name);
        int w = 0;
        while (sb.size() != 0 && w < 500) begin
            @(negedge sys_clk);
            w++;
        end
        check(name, sb.size(), 0);
    endtask

    initial begin
        int c;
        int e;
        int n0;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int e;
        int n0;
        u_if.s_valid = 1'b0;
        u_if.s_data  = '0;

        vecs[0] = '{14'h0100, 14'h0000, 14'h2100, 14'h2000};
        vecs[1] = '{14'h0101, 14'h1FFF, 14'h2101, 14'h3FFF};
        vecs[2] = '{14'h0102, 14'h2000, 14'h2102, 14'h0000};
        vecs[3] = '{14'h3F00, 14'h3FFF, 14'h1F00, 14'h1FFF};
        for (int i = 4; i < 16; i++)
            vecs[i] = '{DW'(14'h0100 + i), DW'(i * 256), DW'(14'h2100 + i), DW'(14'h2000 + i * 256)};

        // reset state
        repeat (3) @(negedge sys_clk);
        check("rst_data1", data1, 14'h2000);
        check("rst_data2", data2, 14'h2000);
        check("rst_wrt1", wrt1_en, 0);
        check("rst_wrt2", wrt2_en, 0);
        check("rst_level", level, 0);
        check("rst_uf", underflow, 0);
        check("rst_uf_cnt", underflow_cnt, 0);
        check("rst_s_ready", u_if.s_ready, 1);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // prefill in IDLE, then paced playback every 4 cycles
        for (int i = 0; i < 16; i++)
            push(vecs[i].ch2, vecs[i].ch1, {vecs[i].exp2, vecs[i].exp1}, 1'b1);
        check("prefill_level", level, 16);
        check("idle_wrt1", wrt1_en, 0);
        have_chg   = 1'b0;
        exp_period = 4;
        mon_en     = 1'b1;
        enable     = 1'b1;
        e = cyc;
        wait_chg(1, "first_tick_seen");
        check("first_tick_cycle", last_chg - e, 6);
        check("run_wrt1", wrt1_en, 1);
        check("run_wrt2", wrt2_en, 1);
        wait_drain("drain_all");

        // underflow with hold, clear, and clear colliding with a set
        c = last_chg;
        wait_cyc(c + 3);
        check("uf_before_tick", underflow, 0);
        wait_cyc(c + 4);
        check("uf_set", underflow, 1);
        check("uf_cnt1", underflow_cnt, 1);
        check("uf_hold", {4'h0, data2, data1}, {4'h0, last_exp});
        wait_cyc(c + 8);
        check("uf_cnt2", underflow_cnt, 2);
        clr_status = 1'b1;
        wait_cyc(c + 9);
        clr_status = 1'b0;
        check("clr_uf", underflow, 0);
        check("clr_uf_cnt", underflow_cnt, 0);
        wait_cyc(c + 11);
        clr_status = 1'b1;
        wait_cyc(c + 12);
        clr_status = 1'b0;
        check("clr_vs_set_uf", underflow, 1);
        check("clr_vs_set_cnt", underflow_cnt, 1);

        // rate_div 3 -> 0 mid-period
        mon_en = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("disable_midscale", data1, 14'h2000);
        for (int i = 0; i < 16; i++)
            push(vecs[i].ch2, vecs[i].ch1, {vecs[i].exp2, vecs[i].exp1}, 1'b1);
        have_chg   = 1'b0;
        exp_period = 4;
        n0         = chg_count;
        mon_en     = 1'b1;
        enable     = 1'b1;
        wait_chg(n0 + 3, "rate_warmup");
        c = last_chg;
        exp_period = 0;
        wait_cyc(c + 1);
        rate_div = 16'd0;
        wait_chg(n0 + 4, "rate_old_seen");
        check("rate_old_period", last_chg - c, 4);
        wait_chg(n0 + 5, "rate_new1_seen");
        check("rate_new_1", last_chg - c, 5);
        wait_chg(n0 + 6, "rate_new2_seen");
        check("rate_new_2", last_chg - c, 6);
        wait_drain("drain_fast");
        check("drain_level", level, 0);

        // fill to full, one tick frees space on the following cycle
        mon_en   = 1'b0;
        enable   = 1'b0;
        rate_div = 16'd3;
        repeat (2) @(negedge sys_clk);
        u_if.s_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            u_if.s_data = {DW'(14'h0555), DW'(i)};
            @(negedge sys_clk);
        end
        check("full_level", level, DEPTH);
        check("full_s_ready", u_if.s_ready, 0);
        enable = 1'b1;
        e = cyc;
        wait_cyc(e + 5);
        check("full_at_tick_ready", u_if.s_ready, 0);
        check("full_at_tick_level", level, DEPTH);
        wait_cyc(e + 6);
        check("after_tick_ready", u_if.s_ready, 1);
        check("after_tick_level", level, DEPTH - 1);
        check("after_tick_data2", data2, 14'h2555);

        // flush in RUN with s_valid high: push dropped
        flush = 1'b1;
        @(negedge sys_clk);
        flush = 1'b0;
        u_if.s_valid = 1'b0;
        check("flush_level", level, 0);
        check("flush_data1", data1, 14'h2000);
        check("flush_data2", data2, 14'h2000);
        check("flush_wrt1", wrt1_en, 0);
        check("flush_wrt2", wrt2_en, 0);

        // reset mid-RUN
        for (int i = 0; i < 16; i++) push(14'h0123, 14'h0456, '0, 1'b0);
        repeat (10) @(negedge sys_clk);
        check("pre_rst_wrt1", wrt1_en, 1);
        check("pre_rst_data1", data1, 14'h2456);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("midrun_rst_data1", data1, 14'h2000);
        check("midrun_rst_data2", data2, 14'h2000);
        check("midrun_rst_wrt1", wrt1_en, 0);
        check("midrun_rst_wrt2", wrt2_en, 0);
        check("midrun_rst_level", level, 0);
        sys_rst = 1'b0;
        enable  = 1'b0;
        repeat (2) @(negedge sys_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
